// File: rtl/dmem_dump_reader_pkg.sv
// rtl/dmem_dump_reader_pkg.sv - shared state encodings and byte-select helper for the memory dump engine
package dmem_dump_reader_pkg;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_FETCH = 2'd1,
    DUMP_SEND  = 2'd2,
    DUMP_DONE  = 2'd3
  } dump_state_t;

  localparam int DUMP_BYTES_PER_WORD = 4;
  localparam logic [1:0] DUMP_LAST_BYTE = 2'(DUMP_BYTES_PER_WORD - 1);

  // Byte 0 is the most significant byte so words leave MSB first.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_dump_reader_if.sv
// rtl/dmem_dump_reader_if.sv - valid/ready byte stream between the dump engine and its consumer
interface dmem_dump_reader_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/dmem_dump_reader_word_byte_serializer.sv
// rtl/dmem_dump_reader_word_byte_serializer.sv - holds one fetched word and presents it as four bytes
module dmem_dump_reader_word_byte_serializer
  import dmem_dump_reader_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      load,
  input  logic [31:0]               load_data,
  dmem_dump_reader_if.master        out_bus,
  output logic                      last_accept
);

  logic [31:0] word_reg;
  logic [1:0]  byte_idx;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        accept;

  assign out_bus.out_data  = data_q;
  assign out_bus.out_valid = valid_q;
  assign accept            = valid_q && out_bus.out_ready;
  assign last_accept       = accept && (byte_idx == DUMP_LAST_BYTE);

  // Load a word, then step through its bytes on each accepted handshake; data holds while stalled.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word_reg <= 32'd0;
      byte_idx <= 2'd0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
    end else if (load) begin
      word_reg <= load_data;
      byte_idx <= 2'd0;
      data_q   <= word_byte(load_data, 2'd0);
      valid_q  <= 1'b1;
    end else if (accept) begin
      if (byte_idx == DUMP_LAST_BYTE) begin
        byte_idx <= 2'd0;
        valid_q  <= 1'b0;
      end else begin
        byte_idx <= byte_idx + 2'd1;
        data_q   <= word_byte(word_reg, byte_idx + 2'd1);
      end
    end
  end

endmodule

// File: rtl/dmem_dump_reader.sv
// rtl/dmem_dump_reader.sv - walks data memory from word 0 upward and streams every word out as bytes
module dmem_dump_reader
  import dmem_dump_reader_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int IDX_W     = 8
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_halted,
  input  logic               start,
  input  logic               abort,
  output logic               mem_rd_en,
  output logic [31:0]        mem_rd_addr,
  input  logic [31:0]        mem_rd_data,
  dmem_dump_reader_if.master out_bus,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(MEM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  dump_state_t      state;
  logic [IDX_W-1:0] word_idx;
  logic             last_accept;

  // Word index to byte address; upper bits stay zero.
  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
    return {{(30 - IDX_W){1'b0}}, idx, 2'b00};
  endfunction

  dmem_dump_reader_word_byte_serializer u_serializer (
    .clk         (clk),
    .reset       (reset),
    .clear       (abort),
    .load        (state == DUMP_FETCH),
    .load_data   (mem_rd_data),
    .out_bus     (out_bus),
    .last_accept (last_accept)
  );

  // Dump sequencer; outputs are registered alongside the state so they match the state they describe.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state       <= DUMP_IDLE;
      word_idx    <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        DUMP_IDLE: begin
          if (start && cpu_halted) begin
            state       <= DUMP_FETCH;
            word_idx    <= '0;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= 32'd0;
            busy        <= 1'b1;
          end
        end
        DUMP_FETCH: begin
          state     <= DUMP_SEND;
          mem_rd_en <= 1'b0;
        end
        DUMP_SEND: begin
          if (last_accept) begin
            if (word_idx == LAST_WORD) begin
              state <= DUMP_DONE;
              done  <= 1'b1;
            end else begin
              state       <= DUMP_FETCH;
              word_idx    <= word_idx + IDX_ONE;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= word_addr(word_idx + IDX_ONE);
            end
          end
        end
        default: begin
          state    <= DUMP_IDLE;
          word_idx <= '0;
          done     <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// tb/tb_dmem_dump_reader.sv - directed self-checking bench for the data-memory dump engine
module tb_dmem_dump_reader;

  logic        clk = 1'b0;
  logic        reset, cpu_halted, start, abort;
  logic        mem_rd_en, busy, done;
  logic [31:0] mem_rd_addr, mem_rd_data;

  logic        s_start, s_abort;
  logic        s_rd_en, s_busy, s_done;
  logic [31:0] s_rd_addr, s_rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_dump_reader_if bus ();
  dmem_dump_reader_if sbus ();

  assign mem_rd_data = 32'hA0B0C000 + (mem_rd_addr >> 2);
  assign s_rd_data   = 32'hA0B0C000 + (s_rd_addr >> 2);

  dmem_dump_reader #(.MEM_WORDS(256), .IDX_W(8)) dut (
    .clk(clk), .reset(reset), .cpu_halted(cpu_halted), .start(start), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_bus(bus.master), .busy(busy), .done(done)
  );

  dmem_dump_reader #(.MEM_WORDS(2), .IDX_W(1)) dut_small (
    .clk(clk), .reset(reset), .cpu_halted(cpu_halted), .start(s_start), .abort(s_abort),
    .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr), .mem_rd_data(s_rd_data),
    .out_bus(sbus.master), .busy(s_busy), .done(s_done)
  );

  // mode 0: ready high; mode 1: random ready with a 10-cycle stall; mode 2: ready high, start spam while busy
  task automatic dump_run(input int mode, output int nbytes, output int errs,
                          output int done_cyc, output int ndone);
    logic [31:0] w;
    logic [7:0]  exp, prev_data;
    bit          prev_stall, stalled;
    int          stall_left;
    nbytes = 0; errs = 0; done_cyc = -1; ndone = 0;
    prev_stall = 0; prev_data = 8'd0; stalled = 0; stall_left = 0;
    @(negedge clk); cpu_halted = 1; start = 1;
    @(negedge clk); start = 0;
    for (int cyc = 1; cyc < 8000; cyc++) begin
      if (mode == 1) begin
        if (!stalled && nbytes == 10 && bus.out_valid) begin stalled = 1; stall_left = 10; end
        if (stall_left > 0) begin bus.out_ready = 0; stall_left--; end
        else bus.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.out_ready = 1;
      end
      if (mode == 2) start = busy && (cyc % 7 == 3);
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data)) errs++;
      if (bus.out_valid && bus.out_ready) begin
        w   = 32'hA0B0C000 + 32'(nbytes / 4);
        exp = 8'(w >> (8 * (3 - nbytes % 4)));
        if (bus.out_data !== exp) errs++;
        nbytes++;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;
      @(negedge clk);
    end
    start = 0; bus.out_ready = 1;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", mem_rd_en); end
    total++; if (mem_rd_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_rd_addr); end
    total++; if (bus.out_data !== 8'd0) begin bad++; $display("FAIL reset_data got=%h want=00", bus.out_data); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
  endtask

  task automatic test_timing();
    @(negedge clk); cpu_halted = 1; start = 1; bus.out_ready = 0;
    @(negedge clk); start = 0;
    total++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL cycle1_fetch got en=%b addr=%h busy=%b want 1/0/1", mem_rd_en, mem_rd_addr, busy); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0 || mem_rd_en !== 1'b0) begin
      bad++; $display("FAIL cycle2_send got v=%b d=%h en=%b want 1/a0/0", bus.out_valid, bus.out_data, mem_rd_en); end
    abort = 1;
    @(negedge clk); abort = 0; bus.out_ready = 1;
    total++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL abort_in_send got busy=%b v=%b want 0/0", busy, bus.out_valid); end
  endtask

  task automatic test_full_dump();
    int nb, er, dc, nd;
    dump_run(0, nb, er, dc, nd);
    total++; if (nb !== 1024) begin bad++; $display("FAIL full_bytes got=%0d want=1024", nb); end
    total++; if (er !== 0) begin bad++; $display("FAIL full_stream got_errs=%0d want=0", er); end
    total++; if (dc !== 1281) begin bad++; $display("FAIL full_done_cycle got=%0d want=1281", dc); end
    total++; if (nd !== 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", nd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_halt_gate();
    int seen = 0;
    @(negedge clk); cpu_halted = 0; start = 1;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || mem_rd_en !== 1'b0) seen++;
    end
    start = 0; cpu_halted = 1;
    total++; if (seen !== 0) begin bad++; $display("FAIL halt_gate got_busy_cycles=%0d want=0", seen); end
  endtask

  task automatic test_start_busy();
    int nb, er, dc, nd;
    dump_run(2, nb, er, dc, nd);
    total++; if (nb !== 1024) begin bad++; $display("FAIL spam_bytes got=%0d want=1024", nb); end
    total++; if (er !== 0) begin bad++; $display("FAIL spam_stream got_errs=%0d want=0", er); end
    total++; if (dc !== 1281 || nd !== 1) begin bad++; $display("FAIL spam_done got=%0d/%0d want=1281/1", dc, nd); end
  endtask

  task automatic test_backpressure();
    int nb, er, dc, nd;
    dump_run(1, nb, er, dc, nd);
    total++; if (nb !== 1024) begin bad++; $display("FAIL bp_bytes got=%0d want=1024", nb); end
    total++; if (er !== 0) begin bad++; $display("FAIL bp_stream got_errs=%0d want=0", er); end
    total++; if (nd !== 1) begin bad++; $display("FAIL bp_done_pulses got=%0d want=1", nd); end
  endtask

  task automatic test_abort();
    int nb = 0;
    int stray = 0;
    bit hit = 0;
    @(negedge clk); cpu_halted = 1; start = 1; bus.out_ready = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 300; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        if (nb == 22) begin hit = 1; break; end
        nb++;
      end
      @(negedge clk);
    end
    total++; if (!hit) begin bad++; $display("FAIL abort_reach got_bytes=%0d want=22", nb); return; end
    total++; if (bus.out_data !== 8'hC0) begin bad++; $display("FAIL abort_byte got=%h want=c0", bus.out_data); end
    abort = 1;
    @(negedge clk); abort = 0;
    total++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_rd_addr !== 32'd0) begin
      bad++; $display("FAIL abort_idle got busy=%b v=%b en=%b addr=%h want 0/0/0/0", busy, bus.out_valid, mem_rd_en, mem_rd_addr); end
    repeat (20) begin
      if (done !== 1'b0 || busy !== 1'b0) stray++;
      @(negedge clk);
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", stray); end
    start = 1;
    @(negedge clk); start = 0;
    total++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'd0) begin
      bad++; $display("FAIL abort_restart got en=%b addr=%h want 1/0", mem_rd_en, mem_rd_addr); end
    abort = 1;
    @(negedge clk); abort = 0;
  endtask

  task automatic test_reset_mid();
    int nb, er, dc, nd;
    bit hit = 0;
    @(negedge clk); cpu_halted = 1; start = 1; bus.out_ready = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 1000; c++) begin
      if (mem_rd_en && mem_rd_addr == 32'd400) begin hit = 1; break; end
      @(negedge clk);
    end
    total++; if (!hit) begin bad++; $display("FAIL rst_mid_reach got=%h want=00000190", mem_rd_addr); end
    reset = 1;
    @(negedge clk); reset = 0;
    total++; if (mem_rd_en !== 1'b0 || mem_rd_addr !== 32'd0 || bus.out_valid !== 1'b0 ||
                 bus.out_data !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_mid_outputs got en=%b addr=%h v=%b d=%h busy=%b done=%b want all 0",
                      mem_rd_en, mem_rd_addr, bus.out_valid, bus.out_data, busy, done); end
    dump_run(0, nb, er, dc, nd);
    total++; if (nb !== 1024 || er !== 0 || nd !== 1) begin
      bad++; $display("FAIL rst_mid_redump got bytes=%0d errs=%0d dones=%0d want 1024/0/1", nb, er, nd); end
  endtask

  task automatic test_small();
    logic [7:0]  exp_bytes [8];
    logic [31:0] addrs [4];
    int nb = 0, na = 0, nd = 0, dc = -1, er = 0;
    exp_bytes = '{8'hA0, 8'hB0, 8'hC0, 8'h00, 8'hA0, 8'hB0, 8'hC0, 8'h01};
    addrs = '{32'd0, 32'd0, 32'd0, 32'd0};
    sbus.out_ready = 1;
    @(negedge clk); cpu_halted = 1; s_start = 1;
    @(negedge clk); s_start = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (s_rd_en) begin
        if (na < 4) addrs[na] = s_rd_addr;
        na++;
      end
      if (sbus.out_valid && sbus.out_ready) begin
        if (nb < 8 && sbus.out_data !== exp_bytes[nb]) er++;
        nb++;
      end
      if (s_done === 1'b1) begin nd++; if (dc < 0) dc = cyc; end
      @(negedge clk);
    end
    total++; if (nb !== 8) begin bad++; $display("FAIL small_bytes got=%0d want=8", nb); end
    total++; if (er !== 0) begin bad++; $display("FAIL small_stream got_errs=%0d want=0", er); end
    total++; if (na !== 2 || addrs[0] !== 32'd0 || addrs[1] !== 32'd4) begin
      bad++; $display("FAIL small_addrs got n=%0d a0=%h a1=%h want 2/0/4", na, addrs[0], addrs[1]); end
    total++; if (nd !== 1 || dc !== 11) begin bad++; $display("FAIL small_done got=%0d@%0d want=1@11", nd, dc); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL small_busy_after got=%b want=0", s_busy); end
  endtask

  initial begin
    reset = 1; cpu_halted = 0; start = 0; abort = 0;
    s_start = 0; s_abort = 0;
    bus.out_ready = 1; sbus.out_ready = 1;
    test_reset();
    test_timing();
    test_full_dump();
    test_halt_gate();
    test_start_busy();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
